// File: rtl/ls161_chain_ctrl.sv
// rtl/ls161_chain_ctrl.sv - sequencer for a cascaded 74LS161 chain used as a modulo-N divider
module ls161_chain_ctrl #(
   parameter  int STAGES = 2,
   localparam int W      = 4 * STAGES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         stop,
   input  logic         cont,
   input  logic [W-1:0] modulus,
   output logic         busy,
   output logic         done,
   output logic         tick,
   output logic         err,
   output logic         ctr_clr_n,
   output logic         ctr_load_n,
   output logic         ctr_enp,
   output logic         ctr_ent,
   output logic [W-1:0] ctr_d,
   input  logic [W-1:0] ctr_q,
   input  logic         ctr_rco
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_CLEAR = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] p_q, p_d;
   logic         cont_q, cont_d;
   logic         tick_q, tick_d;
   logic         done_q, done_d;
   logic         err_q, err_d;
   logic         term;

   // Terminal count is taken only when the chain's Q agrees with its RCO.
   assign term = (state_q == S_RUN) & ctr_rco & (&ctr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         cont_q  <= 1'b0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         cont_q  <= cont_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      cont_d  = cont_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (modulus >= W'(2)) begin
                  p_d     = ~modulus + W'(1);
                  cont_d  = cont;
                  state_d = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            state_d = stop ? S_CLEAR : S_RUN;
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_CLEAR;
            end else if (term) begin
               tick_d = 1'b1;
               if (!cont_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_CLEAR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // A stop coinciding with terminal count is resolved by the CLEAR cycle that follows.
   always_comb begin
      busy       = (state_q != S_IDLE);
      done       = done_q;
      tick       = tick_q;
      err        = err_q;
      ctr_clr_n  = rst_n & (state_q != S_CLEAR);
      ctr_ent    = (state_q == S_RUN);
      ctr_enp    = (state_q == S_RUN) & ~(term & ~cont_q);
      ctr_load_n = ~((state_q == S_LOAD) | (term & cont_q));
      ctr_d      = ((state_q == S_LOAD) || (state_q == S_RUN)) ? p_q : '0;
   end

endmodule

// File: tb/tb_ls161_chain_ctrl.sv
// tb/tb_ls161_chain_ctrl.sv - bench for ls161_chain_ctrl with a behavioural 74LS161 chain
module tb_ls161_chain_ctrl;

   localparam int STAGES = 2;
   localparam int W      = 4 * STAGES;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, stop, cont;
   logic [W-1:0] modulus;
   logic         busy, done, tick, err;
   logic         ctr_clr_n, ctr_load_n, ctr_enp, ctr_ent;
   logic [W-1:0] ctr_d;
   logic [W-1:0] ctr_q;
   logic         ctr_rco;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int obs_tick[$], obs_done[$], obs_err[$];
   int exp_tick[$], exp_done[$], exp_err[$];

   ls161_chain_ctrl #(.STAGES(STAGES)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
      .modulus(modulus), .busy(busy), .done(done), .tick(tick), .err(err),
      .ctr_clr_n(ctr_clr_n), .ctr_load_n(ctr_load_n), .ctr_enp(ctr_enp),
      .ctr_ent(ctr_ent), .ctr_d(ctr_d), .ctr_q(ctr_q), .ctr_rco(ctr_rco)
   );

   always #5 clk = ~clk;

   // Counter chain: async clear, sync load, count when both enables high.
   always_ff @(posedge clk or negedge ctr_clr_n) begin
      if (!ctr_clr_n)       ctr_q <= '0;
      else if (!ctr_load_n) ctr_q <= ctr_d;
      else if (ctr_enp && ctr_ent) ctr_q <= ctr_q + 1'b1;
   end
   assign ctr_rco = (&ctr_q) & ctr_ent;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (tick) obs_tick.push_back(cyc);
         if (done) obs_done.push_back(cyc);
         if (err)  obs_err.push_back(cyc);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_sb();
      obs_tick.delete(); obs_done.delete(); obs_err.delete();
      exp_tick.delete(); exp_done.delete(); exp_err.delete();
   endtask

   task automatic test_reset();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if ({done, tick, err} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {done, tick, err}); end
      n_cmp++; if (ctr_clr_n !== 1'b0) begin n_bad++; $display("FAIL reset_clr_n got %b want 0", ctr_clr_n); end
      n_cmp++; if (ctr_load_n !== 1'b1) begin n_bad++; $display("FAIL reset_load_n got %b want 1", ctr_load_n); end
      n_cmp++; if ({ctr_enp, ctr_ent} !== 2'b00) begin n_bad++; $display("FAIL reset_en got %b want 00", {ctr_enp, ctr_ent}); end
      n_cmp++; if (ctr_d !== 8'h00) begin n_bad++; $display("FAIL reset_d got %h want 00", ctr_d); end
   endtask

   task automatic test_oneshot();
      int t0;
      logic [W-1:0] e;
      clear_sb();
      start = 1'b1; modulus = 8'd5; cont = 1'b0; t0 = cyc;
      exp_tick.push_back(t0 + 7); exp_done.push_back(t0 + 7);
      step(); start = 1'b0;
      n_cmp++; if (ctr_load_n !== 1'b0) begin n_bad++; $display("FAIL os_load_n got %b want 0", ctr_load_n); end
      n_cmp++; if (ctr_d !== 8'hFB) begin n_bad++; $display("FAIL os_preload got %h want fb", ctr_d); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL os_busy got %b want 1", busy); end
      for (int k = 2; k <= 6; k++) begin
         step();
         e = 8'hFB + 8'(k - 2);
         n_cmp++; if (ctr_q !== e) begin n_bad++; $display("FAIL os_q cycle %0d got %h want %h", k, ctr_q, e); end
      end
      step();
      n_cmp++; if ({done, tick, busy} !== 3'b110) begin n_bad++; $display("FAIL os_end got done/tick/busy=%b want 110", {done, tick, busy}); end
      repeat (3) step();
      n_cmp++; if (ctr_q !== 8'hFF) begin n_bad++; $display("FAIL os_hold got %h want ff", ctr_q); end
      n_cmp++; if (obs_tick.size() != exp_tick.size()) begin n_bad++; $display("FAIL os_tick_count got %0d want %0d", obs_tick.size(), exp_tick.size()); end
      n_cmp++; if (obs_done.size() != exp_done.size()) begin n_bad++; $display("FAIL os_done_count got %0d want %0d", obs_done.size(), exp_done.size()); end
      while (exp_tick.size() > 0 && obs_tick.size() > 0) begin
         n_cmp++; if (obs_tick[0] != exp_tick[0]) begin n_bad++; $display("FAIL os_tick_time got %0d want %0d", obs_tick[0], exp_tick[0]); end
         void'(obs_tick.pop_front()); void'(exp_tick.pop_front());
      end
      while (exp_done.size() > 0 && obs_done.size() > 0) begin
         n_cmp++; if (obs_done[0] != exp_done[0]) begin n_bad++; $display("FAIL os_done_time got %0d want %0d", obs_done[0], exp_done[0]); end
         void'(obs_done.pop_front()); void'(exp_done.pop_front());
      end
   endtask

   task automatic test_continuous();
      int t0;
      logic [W-1:0] e;
      clear_sb();
      start = 1'b1; modulus = 8'd3; cont = 1'b1; t0 = cyc;
      for (int i = 0; i < 10; i++) exp_tick.push_back(t0 + 5 + 3 * i);
      step(); start = 1'b0;
      for (int k = 2; k <= 32; k++) begin
         step();
         e = 8'hFD + 8'((k - 2) % 3);
         n_cmp++; if (ctr_q !== e) begin n_bad++; $display("FAIL cont_q cycle %0d got %h want %h", k, ctr_q, e); end
         if (k == 10) begin start = 1'b1; modulus = 8'd7; cont = 1'b0; end
         if (k == 11) start = 1'b0;
      end
      stop = 1'b1;
      step(); stop = 1'b0;
      n_cmp++; if (ctr_clr_n !== 1'b0) begin n_bad++; $display("FAIL cont_clear got %b want 0", ctr_clr_n); end
      step(); step();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_idle got %b want 0", busy); end
      n_cmp++; if (obs_done.size() != 0) begin n_bad++; $display("FAIL cont_done_count got %0d want 0", obs_done.size()); end
      n_cmp++; if (obs_tick.size() != exp_tick.size()) begin n_bad++; $display("FAIL cont_tick_count got %0d want %0d", obs_tick.size(), exp_tick.size()); end
      while (exp_tick.size() > 0 && obs_tick.size() > 0) begin
         n_cmp++; if (obs_tick[0] != exp_tick[0]) begin n_bad++; $display("FAIL cont_tick_time got %0d want %0d", obs_tick[0], exp_tick[0]); end
         void'(obs_tick.pop_front()); void'(exp_tick.pop_front());
      end
   endtask

   task automatic test_stop();
      int t0;
      bit found;
      clear_sb();
      start = 1'b1; modulus = 8'd200; cont = 1'b1; t0 = cyc;
      step(); start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         step();
         if (ctr_q == 8'h80) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_bad++; $display("FAIL stop_wait got no_q80 want q80_seen"); end
      n_cmp++; if (cyc != t0 + 74) begin n_bad++; $display("FAIL stop_q80_time got %0d want %0d", cyc - t0, 74); end
      stop = 1'b1;
      step(); stop = 1'b0;
      n_cmp++; if ({ctr_clr_n, busy, ctr_enp, ctr_ent} !== 4'b0100) begin n_bad++; $display("FAIL stop_clear got clr/busy/enp/ent=%b want 0100", {ctr_clr_n, busy, ctr_enp, ctr_ent}); end
      step();
      n_cmp++; if ({ctr_clr_n, busy} !== 2'b10) begin n_bad++; $display("FAIL stop_idle got clr/busy=%b want 10", {ctr_clr_n, busy}); end
      n_cmp++; if (ctr_q !== 8'h00) begin n_bad++; $display("FAIL stop_q got %h want 00", ctr_q); end
      step(); step();
      n_cmp++; if (obs_tick.size() + obs_done.size() != 0) begin n_bad++; $display("FAIL stop_pulses got %0d want 0", obs_tick.size() + obs_done.size()); end
   endtask

   task automatic test_err();
      int t0;
      for (int nn = 0; nn < 2; nn++) begin
         clear_sb();
         start = 1'b1; modulus = 8'(nn); cont = 1'b1; t0 = cyc;
         exp_err.push_back(t0 + 1);
         step(); start = 1'b0;
         n_cmp++; if ({err, busy, ctr_load_n} !== 3'b101) begin n_bad++; $display("FAIL err_n%0d got err/busy/load_n=%b want 101", nn, {err, busy, ctr_load_n}); end
         step();
         n_cmp++; if ({err, busy, ctr_load_n} !== 3'b001) begin n_bad++; $display("FAIL err_n%0d_after got err/busy/load_n=%b want 001", nn, {err, busy, ctr_load_n}); end
         n_cmp++; if (obs_err.size() != 1 || obs_err[0] != exp_err[0]) begin n_bad++; $display("FAIL err_n%0d_sb got %0d pulses want 1 at %0d", nn, obs_err.size(), exp_err[0]); end
      end
   endtask

   task automatic test_stop_rco();
      clear_sb();
      start = 1'b1; modulus = 8'd3; cont = 1'b1;
      step(); start = 1'b0;
      repeat (3) step();
      n_cmp++; if ({ctr_rco, ctr_q} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL sr_rco got rco=%b q=%h want 1 ff", ctr_rco, ctr_q); end
      stop = 1'b1;
      step(); stop = 1'b0;
      n_cmp++; if ({tick, ctr_clr_n, busy} !== 3'b001) begin n_bad++; $display("FAIL sr_clear got tick/clr/busy=%b want 001", {tick, ctr_clr_n, busy}); end
      n_cmp++; if (ctr_q !== 8'h00) begin n_bad++; $display("FAIL sr_q got %h want 00", ctr_q); end
      step(); step();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sr_idle got %b want 0", busy); end
      n_cmp++; if (obs_tick.size() + obs_done.size() != 0) begin n_bad++; $display("FAIL sr_pulses got %0d want 0", obs_tick.size() + obs_done.size()); end
   endtask

   task automatic test_reset_mid_run();
      int t0;
      clear_sb();
      start = 1'b1; modulus = 8'd10; cont = 1'b1;
      step(); start = 1'b0;
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      test_reset();
      n_cmp++; if (ctr_q !== 8'h00) begin n_bad++; $display("FAIL rmid_q got %h want 00", ctr_q); end
      step(); step();
      rst_n = 1'b1;
      step();
      clear_sb();
      start = 1'b1; modulus = 8'd4; cont = 1'b0; t0 = cyc;
      exp_done.push_back(t0 + 6); exp_tick.push_back(t0 + 6);
      step(); start = 1'b0;
      n_cmp++; if (ctr_d !== 8'hFC) begin n_bad++; $display("FAIL rmid_preload got %h want fc", ctr_d); end
      repeat (5) step();
      n_cmp++; if ({done, tick} !== 2'b11) begin n_bad++; $display("FAIL rmid_done got done/tick=%b want 11", {done, tick}); end
      repeat (3) step();
      n_cmp++; if ({busy, ctr_q} !== {1'b0, 8'hFF}) begin n_bad++; $display("FAIL rmid_end got busy=%b q=%h want 0 ff", busy, ctr_q); end
      n_cmp++; if (obs_done.size() != 1 || obs_done[0] != exp_done[0]) begin n_bad++; $display("FAIL rmid_done_sb got %0d pulses want 1 at %0d", obs_done.size(), exp_done[0]); end
      n_cmp++; if (obs_tick.size() != 1 || obs_tick[0] != exp_tick[0]) begin n_bad++; $display("FAIL rmid_tick_sb got %0d pulses want 1 at %0d", obs_tick.size(), exp_tick[0]); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; modulus = '0;
      step(); step();
      test_reset();
      rst_n = 1'b1;
      step(); step();
      test_oneshot();
      test_continuous();
      test_stop();
      test_err();
      test_stop_rco();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
